multi_operand_collector: RTL



---
 rtl/multi_operand_collector.sv | 285 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/multi_operand_collector.sv
// Operand collector pool: buffers dispatched instructions, gathers register operands through
// per-port round-robin RF reads (tagless, routed back by in-order ID FIFOs), issues complete slots RR.
module multi_operand_collector #(
    parameter int unsigned NumCollectors    = 4,
    parameter int unsigned NumTags          = 8,
    parameter int unsigned PcWidth          = 32,
    parameter int unsigned NumWarps         = 8,
    parameter int unsigned WarpWidth        = 32,
    parameter int unsigned RegIdxWidth      = 6,
    parameter int unsigned OperandsPerInst  = 2,
    parameter int unsigned RegWidth         = 32,
    parameter int unsigned RspFifoDepth     = 4,
    parameter type         inst_t           = logic [31:0],
    localparam int unsigned CidWidth  = (NumCollectors > 1) ? $clog2(NumCollectors) : 1,
    localparam int unsigned TagWidth  = $clog2(NumTags),
    localparam int unsigned WidWidth  = (NumWarps > 1) ? $clog2(NumWarps) : 1,
    localparam int unsigned IidWidth  = TagWidth + WidWidth,
    localparam int unsigned DataWidth = RegWidth * WarpWidth
) (
    input  logic                                              clk_i,
    input  logic                                              rst_ni,
    output logic                                              opc_ready_o,
    input  logic                                              disp_valid_i,
    input  logic [IidWidth-1:0]                               disp_tag_i,
    input  logic [PcWidth-1:0]                                disp_pc_i,
    input  logic [WarpWidth-1:0]                              disp_act_mask_i,
    input  inst_t                                             disp_inst_i,
    input  logic [RegIdxWidth-1:0]                            disp_dst_i,
    input  logic [OperandsPerInst-1:0]                        disp_src_required_i,
    input  logic [OperandsPerInst-1:0][RegIdxWidth-1:0]       disp_src_i,
    output logic [OperandsPerInst-1:0]                        opc_read_req_valid_o,
    output logic [OperandsPerInst-1:0][WidWidth-1:0]          opc_read_req_wid_o,
    output logic [OperandsPerInst-1:0][RegIdxWidth-1:0]       opc_read_req_reg_idx_o,
    input  logic [OperandsPerInst-1:0]                        opc_read_req_ready_i,
    input  logic [OperandsPerInst-1:0]                        opc_read_rsp_valid_i,
    input  logic [OperandsPerInst-1:0][DataWidth-1:0]         opc_read_rsp_data_i,
    input  logic                                              eu_ready_i,
    output logic                                              opc_valid_o,
    output logic [IidWidth-1:0]                               opc_tag_o,
    output logic [PcWidth-1:0]                                opc_pc_o,
    output logic [WarpWidth-1:0]                              opc_act_mask_o,
    output inst_t                                             opc_inst_o,
    output logic [RegIdxWidth-1:0]                            opc_dst_o,
    output logic [OperandsPerInst-1:0][DataWidth-1:0]         opc_operand_data_o
);

    localparam int unsigned Nc       = NumCollectors;
    localparam int unsigned Opi      = OperandsPerInst;
    localparam int unsigned FifoPtrW = (RspFifoDepth > 1) ? $clog2(RspFifoDepth) : 1;
    localparam int unsigned FifoCntW = $clog2(RspFifoDepth) + 1;

    typedef logic [CidWidth-1:0] cid_t;

    function automatic cid_t rr_pick(input logic [Nc-1:0] mask, input cid_t ptr);
        cid_t res;
        logic found;
        res   = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < Nc; k++) begin
            cid_t c;
            c = cid_t'((32'(ptr) + k) % Nc);
            if (!found && mask[c]) begin
                res   = c;
                found = 1'b1;
            end
        end
        return res;
    endfunction

    function automatic cid_t wrap_inc(input cid_t v);
        return (v == cid_t'(Nc - 1)) ? '0 : v + cid_t'(1);
    endfunction

    function automatic logic [FifoPtrW-1:0] fptr_inc(input logic [FifoPtrW-1:0] p);
        return (p == FifoPtrW'(RspFifoDepth - 1)) ? '0 : p + FifoPtrW'(1);
    endfunction

    // Slot control (reset) and payload (no reset; outputs are gated by valid)
    logic [Nc-1:0]                     occ_q, occ_d;
    logic [Opi-1:0]                    reqd_q [Nc];
    logic [Opi-1:0]                    reqd_d [Nc];
    logic [Opi-1:0]                    rdy_q  [Nc];
    logic [Opi-1:0]                    rdy_d  [Nc];
    logic [IidWidth-1:0]               tag_q  [Nc];
    logic [IidWidth-1:0]               tag_d  [Nc];
    logic [PcWidth-1:0]                pc_q   [Nc];
    logic [PcWidth-1:0]                pc_d   [Nc];
    logic [WarpWidth-1:0]              mask_q [Nc];
    logic [WarpWidth-1:0]              mask_d [Nc];
    inst_t                             inst_q [Nc];
    inst_t                             inst_d [Nc];
    logic [RegIdxWidth-1:0]            dst_q  [Nc];
    logic [RegIdxWidth-1:0]            dst_d  [Nc];
    logic [Opi-1:0][RegIdxWidth-1:0]   src_q  [Nc];
    logic [Opi-1:0][RegIdxWidth-1:0]   src_d  [Nc];
    logic [Opi-1:0][DataWidth-1:0]     data_q [Nc];
    logic [Opi-1:0][DataWidth-1:0]     data_d [Nc];

    logic [Nc-1:0]                     cand [Opi];
    cid_t                              rq_sel [Opi];
    cid_t                              rq_ptr_q [Opi];
    cid_t                              rq_hold_slot_q [Opi];
    logic [Opi-1:0]                    rq_hold_q;
    logic [Opi-1:0]                    rq_valid;

    cid_t                              fifo_q [Opi][RspFifoDepth];
    logic [FifoPtrW-1:0]               wr_ptr_q [Opi];
    logic [FifoPtrW-1:0]               rd_ptr_q [Opi];
    logic [FifoCntW-1:0]               cnt_q [Opi];
    logic [Opi-1:0]                    fifo_full, fifo_empty, push, pop;
    cid_t                              head [Opi];

    logic [Nc-1:0]                     complete;
    cid_t                              is_sel, is_ptr_q, is_hold_slot_q, free_idx;
    logic                              is_hold_q, is_valid, is_fire, ins_fire;
    logic [Opi-1:0][DataWidth-1:0]     imm_data;

    assign opc_ready_o = !(&occ_q);
    assign ins_fire    = disp_valid_i && opc_ready_o;
    assign free_idx    = rr_pick(~occ_q, '0);

    always_comb begin
        for (int unsigned i = 0; i < Opi; i++) begin
            cand[i] = '0;
            for (int unsigned s = 0; s < Nc; s++) begin
                cand[i][s] = occ_q[s] && !reqd_q[s][i];
            end
            fifo_full[i]  = (cnt_q[i] == FifoCntW'(RspFifoDepth));
            fifo_empty[i] = (cnt_q[i] == '0);
            // A stalled request keeps its grant; the candidate set can only grow meanwhile
            rq_sel[i]     = rq_hold_q[i] ? rq_hold_slot_q[i] : rr_pick(cand[i], rq_ptr_q[i]);
            rq_valid[i]   = (|cand[i]) && !fifo_full[i];
            push[i]       = rq_valid[i] && opc_read_req_ready_i[i];
            pop[i]        = opc_read_rsp_valid_i[i] && !fifo_empty[i];
            head[i]       = fifo_q[i][rd_ptr_q[i]];
        end
    end

    always_comb begin
        opc_read_req_valid_o   = rq_valid;
        opc_read_req_wid_o     = '0;
        opc_read_req_reg_idx_o = '0;
        for (int unsigned i = 0; i < Opi; i++) begin
            if (rq_valid[i]) begin
                opc_read_req_wid_o[i]     = tag_q[rq_sel[i]][WidWidth-1:0];
                opc_read_req_reg_idx_o[i] = src_q[rq_sel[i]][i];
            end
        end
    end

    always_comb begin
        for (int unsigned s = 0; s < Nc; s++) begin
            complete[s] = occ_q[s] && (&rdy_q[s]);
        end
        is_sel   = is_hold_q ? is_hold_slot_q : rr_pick(complete, is_ptr_q);
        is_valid = |complete;
        is_fire  = is_valid && eu_ready_i;
    end

    always_comb begin
        opc_valid_o        = is_valid;
        opc_tag_o          = '0;
        opc_pc_o           = '0;
        opc_act_mask_o     = '0;
        opc_inst_o         = '0;
        opc_dst_o          = '0;
        opc_operand_data_o = '0;
        if (is_valid) begin
            opc_tag_o          = tag_q[is_sel];
            opc_pc_o           = pc_q[is_sel];
            opc_act_mask_o     = mask_q[is_sel];
            opc_inst_o         = inst_q[is_sel];
            opc_dst_o          = dst_q[is_sel];
            opc_operand_data_o = data_q[is_sel];
        end
    end

    // Non-register operands carry their source index as an immediate in every thread lane
    always_comb begin
        imm_data = '0;
        for (int unsigned i = 0; i < Opi; i++) begin
            for (int unsigned t = 0; t < WarpWidth; t++) begin
                imm_data[i][t*RegWidth + i*RegIdxWidth +: RegIdxWidth] = disp_src_i[i];
            end
        end
    end

    always_comb begin
        occ_d  = occ_q;
        reqd_d = reqd_q;
        rdy_d  = rdy_q;
        tag_d  = tag_q;
        pc_d   = pc_q;
        mask_d = mask_q;
        inst_d = inst_q;
        dst_d  = dst_q;
        src_d  = src_q;
        data_d = data_q;
        for (int unsigned i = 0; i < Opi; i++) begin
            if (push[i]) reqd_d[rq_sel[i]][i] = 1'b1;
            if (pop[i]) begin
                rdy_d[head[i]][i]  = 1'b1;
                data_d[head[i]][i] = opc_read_rsp_data_i[i];
            end
        end
        if (is_fire) occ_d[is_sel] = 1'b0;
        if (ins_fire) begin
            occ_d[free_idx]  = 1'b1;
            tag_d[free_idx]  = disp_tag_i;
            pc_d[free_idx]   = disp_pc_i;
            mask_d[free_idx] = disp_act_mask_i;
            inst_d[free_idx] = disp_inst_i;
            dst_d[free_idx]  = disp_dst_i;
            src_d[free_idx]  = disp_src_i;
            reqd_d[free_idx] = ~disp_src_required_i;
            rdy_d[free_idx]  = ~disp_src_required_i;
            for (int unsigned i = 0; i < Opi; i++) begin
                data_d[free_idx][i] = disp_src_required_i[i] ? '0 : imm_data[i];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            occ_q          <= '0;
            is_ptr_q       <= '0;
            is_hold_q      <= 1'b0;
            is_hold_slot_q <= '0;
            rq_hold_q      <= '0;
            for (int unsigned s = 0; s < Nc; s++) begin
                reqd_q[s] <= '0;
                rdy_q[s]  <= '0;
            end
            for (int unsigned i = 0; i < Opi; i++) begin
                rq_ptr_q[i]       <= '0;
                rq_hold_slot_q[i] <= '0;
                wr_ptr_q[i]       <= '0;
                rd_ptr_q[i]       <= '0;
                cnt_q[i]          <= '0;
            end
        end else begin
            occ_q          <= occ_d;
            reqd_q         <= reqd_d;
            rdy_q          <= rdy_d;
            is_hold_q      <= is_valid && !eu_ready_i;
            is_hold_slot_q <= is_sel;
            if (is_fire) is_ptr_q <= wrap_inc(is_sel);
            for (int unsigned i = 0; i < Opi; i++) begin
                rq_hold_q[i]      <= rq_valid[i] && !opc_read_req_ready_i[i];
                rq_hold_slot_q[i] <= rq_sel[i];
                if (push[i]) begin
                    rq_ptr_q[i] <= wrap_inc(rq_sel[i]);
                    wr_ptr_q[i] <= fptr_inc(wr_ptr_q[i]);
                end
                if (pop[i]) rd_ptr_q[i] <= fptr_inc(rd_ptr_q[i]);
                cnt_q[i] <= cnt_q[i] + FifoCntW'(push[i]) - FifoCntW'(pop[i]);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        tag_q  <= tag_d;
        pc_q   <= pc_d;
        mask_q <= mask_d;
        inst_q <= inst_d;
        dst_q  <= dst_d;
        src_q  <= src_d;
        data_q <= data_d;
        for (int unsigned i = 0; i < Opi; i++) begin
            if (push[i]) fifo_q[i][wr_ptr_q[i]] <= rq_sel[i];
        end
    end

    for (genvar gi = 0; gi < Opi; gi++) begin : g_port_chk
        a_rsp_nonempty: assert property (@(posedge clk_i) disable iff (!rst_ni)
            opc_read_rsp_valid_i[gi] |-> !fifo_empty[gi]);
        a_req_occupied: assert property (@(posedge clk_i) disable iff (!rst_ni)
            rq_valid[gi] |-> occ_q[rq_sel[gi]]);
    end

    a_imm_fits: assert property (@(posedge clk_i) (Opi * RegIdxWidth) <= RegWidth);
    a_depth_pow2: assert property (@(posedge clk_i)
        (RspFifoDepth >= 1) && ((RspFifoDepth & (RspFifoDepth - 1)) == 0));

endmodule
